// File: rtl/alignment_marker_rx.sv
// alignment_marker_rx
//   Receive-side alignment marker handling for a 4-lane 40GBASE-R PCS.
//   Per physical lane it searches for the periodic alignment marker, runs a
//   find / confirm / locked state machine, reports the logical lane number
//   carried by the marker and flags marker slots so downstream logic can
//   drop them. Head and data are passed through with one register stage.
//
// Ports
//   clk         clock, one 66b block per lane per cycle
//   nreset      asynchronous active-low reset
//   head_i      per-lane sync headers, lane l at [l*HEAD_W +: HEAD_W]
//   data_i      per-lane payloads, lane l at [l*DATA_W +: DATA_W]
//   head_o      head_i delayed one cycle
//   data_o      data_i delayed one cycle
//   marker_v_o  lane l output block sits in a marker slot
//   am_lock_o   per-lane marker lock
//   lane_id_o   logical lane number found on physical lane l (2 bits each)
//   align_ok_o  all lanes locked and lane ids form a permutation
//   bip_err_o   (only with ALIGNMENT_MARKER_RX_BIP_EN) per-lane BIP3 error pulse
//
// Build option
//   ALIGNMENT_MARKER_RX_BIP_EN : adds the per-lane BIP3 checker and bip_err_o.

module alignment_marker_rx #(
  parameter int                LANE_N    = 4,
  parameter int                HEAD_W    = 2,
  parameter int                DATA_W    = 64,
  parameter int                AM_PERIOD = 16383,
  parameter logic [HEAD_W-1:0] SYNC_CTRL = 2'b10
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [LANE_N*HEAD_W-1:0]   head_i,
  input  logic [LANE_N*DATA_W-1:0]   data_i,
  output logic [LANE_N*HEAD_W-1:0]   head_o,
  output logic [LANE_N*DATA_W-1:0]   data_o,
  output logic [LANE_N-1:0]          marker_v_o,
  output logic [LANE_N-1:0]          am_lock_o,
  output logic [LANE_N*2-1:0]        lane_id_o,
  output logic                       align_ok_o
`ifdef ALIGNMENT_MARKER_RX_BIP_EN
  ,
  output logic [LANE_N-1:0]          bip_err_o
`endif
);

  localparam int CNT_W = (AM_PERIOD > 0) ? $clog2(AM_PERIOD + 1) : 1;
  localparam logic [CNT_W-1:0] AM_LAST = CNT_W'(AM_PERIOD);

  typedef enum logic [1:0] {
    FIND_1ST = 2'd0,
    COUNT_1  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Returns {hit, lane}. BIP bytes 3 and 7 do not take part in the match.
  function automatic logic [2:0] am_decode(input logic [HEAD_W-1:0] head,
                                           input logic [DATA_W-1:0] data);
    logic [2:0] res;
    res = 3'b000;
    if (head == SYNC_CTRL && data[55:32] == ~data[23:0]) begin
      case (data[23:0])
        24'h477690: res = 3'b100;
        24'hE6C4F0: res = 3'b101;
        24'h9B65C5: res = 3'b110;
        24'h3D79A2: res = 3'b111;
        default:    res = 3'b000;
      endcase
    end
    return res;
  endfunction

  logic [HEAD_W*LANE_N-1:0] head_q;
  logic [DATA_W*LANE_N-1:0] data_q;

  state_t            state_q     [LANE_N];
  state_t            state_d     [LANE_N];
  logic [CNT_W-1:0]  blk_cnt_q   [LANE_N];
  logic [CNT_W-1:0]  blk_cnt_d   [LANE_N];
  logic [1:0]        cand_id_q   [LANE_N];
  logic [1:0]        cand_id_d   [LANE_N];
  logic [2:0]        invld_cnt_q [LANE_N];
  logic [2:0]        invld_cnt_d [LANE_N];
  logic [LANE_N*2-1:0] lane_id_q, lane_id_d;
  logic [LANE_N-1:0]   am_lock_q, am_lock_d;
  logic [LANE_N-1:0]   marker_v_q, marker_v_d;

  logic [2:0]        dec     [LANE_N];
  logic [LANE_N-1:0] at_slot;

  for (genvar g = 0; g < LANE_N; g++) begin : g_lane
    assign dec[g]     = am_decode(head_i[g*HEAD_W +: HEAD_W], data_i[g*DATA_W +: DATA_W]);
    assign at_slot[g] = (blk_cnt_q[g] == AM_LAST);
  end

  // Per-lane marker lock state machine; blk_cnt counts blocks since the last slot.
  always_comb begin
    for (int l = 0; l < LANE_N; l++) begin
      state_d[l]             = state_q[l];
      blk_cnt_d[l]           = blk_cnt_q[l];
      cand_id_d[l]           = cand_id_q[l];
      invld_cnt_d[l]         = invld_cnt_q[l];
      lane_id_d[l*2 +: 2]    = lane_id_q[l*2 +: 2];
      am_lock_d[l]           = am_lock_q[l];
      marker_v_d[l]          = 1'b0;
      case (state_q[l])
        FIND_1ST: begin
          blk_cnt_d[l] = '0;
          if (dec[l][2]) begin
            state_d[l]   = COUNT_1;
            cand_id_d[l] = dec[l][1:0];
          end
        end
        COUNT_1: begin
          if (at_slot[l]) begin
            blk_cnt_d[l] = '0;
            if (dec[l][2] && dec[l][1:0] == cand_id_q[l]) begin
              state_d[l]          = LOCKED;
              lane_id_d[l*2 +: 2] = cand_id_q[l];
              am_lock_d[l]        = 1'b1;
              invld_cnt_d[l]      = 3'd0;
              marker_v_d[l]       = 1'b1;
            end else begin
              // The failed confirm block is not searched again.
              state_d[l] = FIND_1ST;
            end
          end else begin
            blk_cnt_d[l] = blk_cnt_q[l] + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (at_slot[l]) begin
            blk_cnt_d[l]  = '0;
            marker_v_d[l] = 1'b1;
            if (dec[l][2] && dec[l][1:0] == lane_id_q[l*2 +: 2]) begin
              invld_cnt_d[l] = 3'd0;
            end else if (invld_cnt_q[l] == 3'd3) begin
              state_d[l]          = FIND_1ST;
              am_lock_d[l]        = 1'b0;
              lane_id_d[l*2 +: 2] = 2'd0;
              invld_cnt_d[l]      = 3'd0;
            end else begin
              invld_cnt_d[l] = invld_cnt_q[l] + 3'd1;
            end
          end else begin
            blk_cnt_d[l] = blk_cnt_q[l] + CNT_W'(1);
          end
        end
        default: begin
          state_d[l] = FIND_1ST;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      head_q     <= '0;
      data_q     <= '0;
      lane_id_q  <= '0;
      am_lock_q  <= '0;
      marker_v_q <= '0;
      for (int l = 0; l < LANE_N; l++) begin
        state_q[l]     <= FIND_1ST;
        blk_cnt_q[l]   <= '0;
        cand_id_q[l]   <= 2'd0;
        invld_cnt_q[l] <= 3'd0;
      end
    end else begin
      head_q     <= head_i;
      data_q     <= data_i;
      lane_id_q  <= lane_id_d;
      am_lock_q  <= am_lock_d;
      marker_v_q <= marker_v_d;
      for (int l = 0; l < LANE_N; l++) begin
        state_q[l]     <= state_d[l];
        blk_cnt_q[l]   <= blk_cnt_d[l];
        cand_id_q[l]   <= cand_id_d[l];
        invld_cnt_q[l] <= invld_cnt_d[l];
      end
    end
  end

  // Alignment is good only when every lane is locked and no two share an id.
  logic align_ok;
  always_comb begin
    align_ok = &am_lock_q;
    for (int i = 0; i < LANE_N; i++) begin
      for (int j = i + 1; j < LANE_N; j++) begin
        if (lane_id_q[i*2 +: 2] == lane_id_q[j*2 +: 2]) begin
          align_ok = 1'b0;
        end
      end
    end
  end

  assign head_o     = head_q;
  assign data_o     = data_q;
  assign marker_v_o = marker_v_q;
  assign am_lock_o  = am_lock_q;
  assign lane_id_o  = lane_id_q;
  assign align_ok_o = align_ok;

`ifdef ALIGNMENT_MARKER_RX_BIP_EN
  // BIP bytes 3 and 7 of the marker enter the accumulator as zero.
  localparam logic [DATA_W-1:0] BIP_MASK = DATA_W'(64'h00FF_FFFF_00FF_FFFF);

  // Bit j is the XOR of data bits j+8i; head bits fold into bits 3 and 4.
  function automatic logic [7:0] bip_calc(input logic [HEAD_W-1:0] head,
                                          input logic [DATA_W-1:0] data);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < DATA_W / 8; i++) begin
      b = b ^ data[i*8 +: 8];
    end
    b[3] = b[3] ^ head[0];
    b[4] = b[4] ^ head[1];
    return b;
  endfunction

  logic [7:0]        bip_acc_q [LANE_N];
  logic [7:0]        bip_acc_d [LANE_N];
  logic [LANE_N-1:0] bip_first_q, bip_first_d;
  logic [LANE_N-1:0] bip_err_q, bip_err_d;

  always_comb begin
    for (int l = 0; l < LANE_N; l++) begin
      bip_first_d[l] = bip_first_q[l];
      bip_err_d[l]   = 1'b0;
      // The accumulator restarts on every marker slot, and on the first
      // marker found while searching, so its span always begins at a marker.
      if ((state_q[l] == FIND_1ST && dec[l][2]) ||
          (state_q[l] != FIND_1ST && at_slot[l])) begin
        bip_acc_d[l] = bip_calc(head_i[l*HEAD_W +: HEAD_W],
                                data_i[l*DATA_W +: DATA_W] & BIP_MASK);
      end else begin
        bip_acc_d[l] = bip_acc_q[l] ^ bip_calc(head_i[l*HEAD_W +: HEAD_W],
                                               data_i[l*DATA_W +: DATA_W]);
      end
      if (state_q[l] == COUNT_1 && at_slot[l] && dec[l][2] &&
          dec[l][1:0] == cand_id_q[l]) begin
        bip_first_d[l] = 1'b1;
      end
      if (state_q[l] == LOCKED && at_slot[l]) begin
        bip_first_d[l] = 1'b0;
        if (dec[l][2] && dec[l][1:0] == lane_id_q[l*2 +: 2] && !bip_first_q[l]) begin
          bip_err_d[l] = (bip_acc_q[l] != data_i[l*DATA_W + 24 +: 8]) ||
                         (data_i[l*DATA_W + 56 +: 8] != ~data_i[l*DATA_W + 24 +: 8]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bip_first_q <= '0;
      bip_err_q   <= '0;
      for (int l = 0; l < LANE_N; l++) begin
        bip_acc_q[l] <= 8'h00;
      end
    end else begin
      bip_first_q <= bip_first_d;
      bip_err_q   <= bip_err_d;
      for (int l = 0; l < LANE_N; l++) begin
        bip_acc_q[l] <= bip_acc_d[l];
      end
    end
  end

  assign bip_err_o = bip_err_q;
`endif

endmodule

// File: tb/tb_alignment_marker_rx.sv
// Testbench for alignment_marker_rx with a short marker period (AM_PERIOD=15).
// A transmit-side generator builds random data blocks and markers (with BIP3)
// per lane at a per-lane random phase; a reference model derives the expected
// lock, lane id, marker flags and alignment from absolute block positions.

module tb_alignment_marker_rx;

  localparam int LN = 4;
  localparam int P  = 15;
  localparam int P1 = P + 1;

  logic          clk = 1'b0;
  logic          nreset = 1'b1;
  logic [7:0]    head_i = '0;
  logic [255:0]  data_i = '0;
  logic [7:0]    head_o;
  logic [255:0]  data_o;
  logic [3:0]    marker_v_o, am_lock_o;
  logic [7:0]    lane_id_o;
  logic          align_ok_o;
`ifdef ALIGNMENT_MARKER_RX_BIP_EN
  logic [3:0]    bip_err_o;
`endif

  always #5 clk = ~clk;

  alignment_marker_rx #(.LANE_N(LN), .HEAD_W(2), .DATA_W(64), .AM_PERIOD(P),
                        .SYNC_CTRL(2'b10)) dut (
    .clk(clk), .nreset(nreset), .head_i(head_i), .data_i(data_i),
    .head_o(head_o), .data_o(data_o), .marker_v_o(marker_v_o),
    .am_lock_o(am_lock_o), .lane_id_o(lane_id_o), .align_ok_o(align_ok_o)
`ifdef ALIGNMENT_MARKER_RX_BIP_EN
    , .bip_err_o(bip_err_o)
`endif
  );

  int errors = 0;
  int checks = 0;
  int gcyc = 0;

  logic [23:0] am_tab [4] = '{24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2};

  // generator controls
  int         src [4];
  int         ph [4];
  int         drop_cnt [4];
  int         bad_cnt [4];
  bit         corrupt [4];
  bit         pend [4];
  logic [7:0] txacc [4];

  // reference model state: 0 searching, 1 confirming, 2 locked
  int mmode [4];
  int anchor [4];
  int mcand [4];
  int mmiss [4];

  logic [3:0]   exp_lock, exp_mv, exp_bip;
  logic [7:0]   exp_id;
  logic         exp_ok;
  logic [7:0]   exp_head;
  logic [255:0] exp_data;

  function automatic logic [7:0] bip8(input logic [1:0] h, input logic [63:0] d);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 64; k++) b[k % 8] = b[k % 8] ^ d[k];
    b[3] = b[3] ^ h[0];
    b[4] = b[4] ^ h[1];
    return b;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < LN; l++) begin
      mmode[l] = 0; anchor[l] = 0; mcand[l] = 0; mmiss[l] = 0;
      drop_cnt[l] = 0; bad_cnt[l] = 0; corrupt[l] = 0; pend[l] = 0;
      src[l] = l; ph[l] = $urandom_range(0, P);
    end
    exp_lock = '0; exp_mv = '0; exp_bip = '0; exp_id = '0; exp_ok = 1'b0;
    exp_head = '0; exp_data = '0;
  endtask

  task automatic model_lane(input int l, input logic [1:0] h, input logic [63:0] d);
    int k;
    bit slot, good;
    k = -1;
    if (h == 2'b10 && d[55:32] == ~d[23:0])
      for (int m = 0; m < 4; m++) if (d[23:0] == am_tab[m]) k = m;
    exp_mv[l] = 1'b0;
    exp_bip[l] = 1'b0;
    slot = (mmode[l] != 0) && (((gcyc - anchor[l]) % P1) == 0);
    if (mmode[l] == 0) begin
      if (k >= 0) begin mmode[l] = 1; mcand[l] = k; anchor[l] = gcyc; end
    end else if (slot && mmode[l] == 1) begin
      if (k == mcand[l]) begin
        mmode[l] = 2; exp_lock[l] = 1'b1; exp_id[2*l +: 2] = 2'(mcand[l]);
        mmiss[l] = 0; exp_mv[l] = 1'b1;
      end else mmode[l] = 0;
    end else if (slot && mmode[l] == 2) begin
      exp_mv[l] = 1'b1;
      good = (k >= 0) && (k == int'(exp_id[2*l +: 2]));
      if (good) begin
        mmiss[l] = 0;
        if (pend[l]) begin exp_bip[l] = 1'b1; pend[l] = 0; end
      end else begin
        mmiss[l]++;
        if (mmiss[l] == 4) begin
          mmode[l] = 0; exp_lock[l] = 1'b0; exp_id[2*l +: 2] = 2'd0; mmiss[l] = 0;
        end
      end
    end
  endtask

  task automatic step();
    logic [1:0]  h;
    logic [63:0] d;
    bit          slot;
    int          id, bitpos;
    logic [3:0]  seen;
    for (int l = 0; l < LN; l++) begin
      slot = (((gcyc + P1 * 8 - ph[l]) % P1) == 0);
      h = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      d = {$urandom, $urandom};
      if (slot && drop_cnt[l] > 0) drop_cnt[l]--;
      else if (slot) begin
        id = src[l];
        if (bad_cnt[l] > 0) begin id = (id + 1) % 4; bad_cnt[l]--; end
        h = 2'b10;
        d = {~txacc[l], ~am_tab[id], txacc[l], am_tab[id]};
      end
      if (slot) txacc[l] = bip8(h, d & 64'h00FF_FFFF_00FF_FFFF);
      else txacc[l] = txacc[l] ^ bip8(h, d);
      if (!slot && corrupt[l]) begin
        bitpos = $urandom_range(0, 63);
        d[bitpos] = ~d[bitpos];
        corrupt[l] = 0; pend[l] = 1;
      end
      head_i[2*l +: 2] = h;
      data_i[64*l +: 64] = d;
      model_lane(l, h, d);
    end
    seen = '0;
    for (int l = 0; l < LN; l++) seen[exp_id[2*l +: 2]] = 1'b1;
    exp_ok = (exp_lock == 4'hF) && (seen == 4'hF);
    exp_head = head_i;
    exp_data = data_i;
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    #2 nreset = 1'b0;
    #1;
    model_clear();
    checks++; if (am_lock_o !== 4'h0) begin errors++; $display("FAIL reset_lock got=%h want=0", am_lock_o); end
    checks++; if (marker_v_o !== 4'h0) begin errors++; $display("FAIL reset_mv got=%h want=0", marker_v_o); end
    checks++; if (lane_id_o !== 8'h00) begin errors++; $display("FAIL reset_id got=%h want=0", lane_id_o); end
    checks++; if (align_ok_o !== 1'b0) begin errors++; $display("FAIL reset_ok got=%b want=0", align_ok_o); end
    checks++; if ({head_o, data_o} !== '0) begin errors++; $display("FAIL reset_data got head=%h want 0", head_o); end
    @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  task automatic test_in_order();
    int mvc [4];
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if ({head_o, data_o, marker_v_o, am_lock_o, lane_id_o, align_ok_o} !==
          {exp_head, exp_data, exp_mv, exp_lock, exp_id, exp_ok}) begin
        errors++;
        $display("FAIL in_order cyc=%0d got mv=%h lock=%h id=%h ok=%b want mv=%h lock=%h id=%h ok=%b",
                 c, marker_v_o, am_lock_o, lane_id_o, align_ok_o, exp_mv, exp_lock, exp_id, exp_ok);
      end
    end
    checks++; if (am_lock_o !== 4'hF) begin errors++; $display("FAIL in_order_lock got=%h want=f", am_lock_o); end
    checks++; if (lane_id_o !== 8'hE4) begin errors++; $display("FAIL in_order_id got=%h want=e4", lane_id_o); end
    checks++; if (align_ok_o !== 1'b1) begin errors++; $display("FAIL in_order_ok got=%b want=1", align_ok_o); end
    for (int l = 0; l < LN; l++) mvc[l] = 0;
    for (int c = 0; c < P1; c++) begin
      step();
      for (int l = 0; l < LN; l++) if (marker_v_o[l] === 1'b1) mvc[l]++;
    end
    for (int l = 0; l < LN; l++) begin
      checks++;
      if (mvc[l] != 1) begin errors++; $display("FAIL marker_rate lane=%0d got=%0d want=1", l, mvc[l]); end
    end
  endtask

  task automatic test_swap();
    apply_reset();
    src[0] = 2; src[2] = 0;
    for (int c = 0; c < 48; c++) begin
      step();
      checks++;
      if ({marker_v_o, am_lock_o, lane_id_o, align_ok_o} !== {exp_mv, exp_lock, exp_id, exp_ok}) begin
        errors++;
        $display("FAIL swap cyc=%0d got mv=%h lock=%h id=%h ok=%b want mv=%h lock=%h id=%h ok=%b",
                 c, marker_v_o, am_lock_o, lane_id_o, align_ok_o, exp_mv, exp_lock, exp_id, exp_ok);
      end
    end
    checks++; if (lane_id_o[1:0] !== 2'd2) begin errors++; $display("FAIL swap_id0 got=%0d want=2", lane_id_o[1:0]); end
    checks++; if (lane_id_o[5:4] !== 2'd0) begin errors++; $display("FAIL swap_id2 got=%0d want=0", lane_id_o[5:4]); end
    checks++; if (align_ok_o !== 1'b1) begin errors++; $display("FAIL swap_ok got=%b want=1", align_ok_o); end
  endtask

  task automatic test_lane_loss();
    bit saw_unlock;
    apply_reset();
    for (int c = 0; c < 40; c++) step();
    drop_cnt[1] = 3;
    saw_unlock = 0;
    for (int c = 0; c < 5 * P1; c++) begin
      step();
      if (am_lock_o[1] !== 1'b1) saw_unlock = 1;
      checks++;
      if ({marker_v_o, am_lock_o, lane_id_o} !== {exp_mv, exp_lock, exp_id}) begin
        errors++;
        $display("FAIL miss3 cyc=%0d got mv=%h lock=%h id=%h want mv=%h lock=%h id=%h",
                 c, marker_v_o, am_lock_o, lane_id_o, exp_mv, exp_lock, exp_id);
      end
    end
    checks++; if (saw_unlock) begin errors++; $display("FAIL miss3_hold got unlock=1 want=0"); end
    drop_cnt[1] = 4;
    saw_unlock = 0;
    for (int c = 0; c < 7 * P1; c++) begin
      step();
      if (am_lock_o[1] === 1'b0) saw_unlock = 1;
      checks++;
      if ({marker_v_o, am_lock_o, lane_id_o, align_ok_o} !== {exp_mv, exp_lock, exp_id, exp_ok}) begin
        errors++;
        $display("FAIL miss4 cyc=%0d got mv=%h lock=%h id=%h ok=%b want mv=%h lock=%h id=%h ok=%b",
                 c, marker_v_o, am_lock_o, lane_id_o, align_ok_o, exp_mv, exp_lock, exp_id, exp_ok);
      end
    end
    checks++; if (!saw_unlock) begin errors++; $display("FAIL miss4_unlock got unlock=0 want=1"); end
    checks++; if (am_lock_o !== 4'hF) begin errors++; $display("FAIL miss4_relock got=%h want=f", am_lock_o); end
  endtask

  task automatic test_bad_second();
    int  n;
    bit  saw_lock;
    apply_reset();
    n = 0;
    while (mmode[0] != 1 && n < P1 + 2) begin step(); n++; end
    checks++;
    if (mmode[0] != 1) begin errors++; $display("FAIL bad2_first got no marker within %0d cycles want one", n); end
    bad_cnt[0] = 1;
    saw_lock = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (am_lock_o[0] !== 1'b0) saw_lock = 1;
      checks++;
      if ({marker_v_o, am_lock_o, lane_id_o} !== {exp_mv, exp_lock, exp_id}) begin
        errors++;
        $display("FAIL bad2 cyc=%0d got mv=%h lock=%h id=%h want mv=%h lock=%h id=%h",
                 c, marker_v_o, am_lock_o, lane_id_o, exp_mv, exp_lock, exp_id);
      end
    end
    checks++; if (saw_lock) begin errors++; $display("FAIL bad2_nolock got lock0=1 want=0"); end
    for (int c = 0; c < P1; c++) step();
    checks++; if (am_lock_o[0] !== 1'b1) begin errors++; $display("FAIL bad2_relock got=%b want=1", am_lock_o[0]); end
  endtask

  task automatic test_dup_id();
    apply_reset();
    src[1] = 0;
    for (int c = 0; c < 48; c++) begin
      step();
      checks++;
      if ({marker_v_o, am_lock_o, lane_id_o, align_ok_o} !== {exp_mv, exp_lock, exp_id, exp_ok}) begin
        errors++;
        $display("FAIL dup cyc=%0d got mv=%h lock=%h id=%h ok=%b want mv=%h lock=%h id=%h ok=%b",
                 c, marker_v_o, am_lock_o, lane_id_o, align_ok_o, exp_mv, exp_lock, exp_id, exp_ok);
      end
    end
    checks++; if (am_lock_o !== 4'hF) begin errors++; $display("FAIL dup_lock got=%h want=f", am_lock_o); end
    checks++; if (align_ok_o !== 1'b0) begin errors++; $display("FAIL dup_ok got=%b want=0", align_ok_o); end
  endtask

  task automatic test_reset_locked();
    checks++; if (am_lock_o !== 4'hF) begin errors++; $display("FAIL prereset_lock got=%h want=f", am_lock_o); end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({head_o, data_o, marker_v_o, am_lock_o, lane_id_o, align_ok_o} !== '0) begin
      errors++;
      $display("FAIL async_reset got mv=%h lock=%h id=%h ok=%b want all 0",
               marker_v_o, am_lock_o, lane_id_o, align_ok_o);
    end
    model_clear();
    @(posedge clk);
    #1 nreset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if ({head_o, data_o, marker_v_o, am_lock_o, lane_id_o, align_ok_o} !==
          {exp_head, exp_data, exp_mv, exp_lock, exp_id, exp_ok}) begin
        errors++;
        $display("FAIL relock cyc=%0d got mv=%h lock=%h id=%h ok=%b want mv=%h lock=%h id=%h ok=%b",
                 c, marker_v_o, am_lock_o, lane_id_o, align_ok_o, exp_mv, exp_lock, exp_id, exp_ok);
      end
    end
    checks++; if (am_lock_o !== 4'hF) begin errors++; $display("FAIL relock_final got=%h want=f", am_lock_o); end
  endtask

`ifdef ALIGNMENT_MARKER_RX_BIP_EN
  task automatic test_bip();
    int pulses;
    apply_reset();
    for (int c = 0; c < 5 * P1; c++) step();
    corrupt[3] = 1;
    pulses = 0;
    for (int c = 0; c < 3 * P1; c++) begin
      step();
      if (bip_err_o[3] === 1'b1) pulses++;
      checks++;
      if ({bip_err_o, marker_v_o} !== {exp_bip, exp_mv}) begin
        errors++;
        $display("FAIL bip cyc=%0d got err=%h mv=%h want err=%h mv=%h",
                 c, bip_err_o, marker_v_o, exp_bip, exp_mv);
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL bip_pulses got=%0d want=1", pulses); end
  endtask
`endif

  initial begin
    for (int l = 0; l < LN; l++) txacc[l] = 8'h00;
    test_reset();
    test_in_order();
    test_reset_locked();
    test_swap();
    test_lane_loss();
    test_bad_second();
    test_dup_id();
`ifdef ALIGNMENT_MARKER_RX_BIP_EN
    test_bip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
